// File: rtl/sqrt_unit_if.sv
// ---------------------------------------------------------------------------
// sqrt_unit_if
//
// Request/response bundle for the square-root engine.
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. Once valid is raised, the source holds valid and
// its payload unchanged until that edge. Ready may go up or down at any time
// and never depends combinationally on valid. This applies to both the
// request channel (in_*) and the result channel (out_*).
//
// Signals:
//   in_valid     request valid            (producer -> engine)
//   in_ready     engine can accept        (engine -> producer)
//   in_radicand  unsigned squared distance, IN_W bits
//   in_tag       caller tag, TAG_W bits
//   out_valid    result valid             (engine -> consumer)
//   out_ready    consumer accepts result  (consumer -> engine)
//   out_root     fixed-point root, OUT_W bits with FRAC_W fraction bits
//   out_exact    final remainder was zero
//   out_tag      tag captured with the request
//
// Modports:
//   master  the producer/consumer side (testbench or surrounding datapath)
//   slave   the engine
// ---------------------------------------------------------------------------
interface sqrt_unit_if #(
  parameter int IN_W   = 20,
  parameter int FRAC_W = 4,
  parameter int TAG_W  = 8
);
  localparam int OUT_W = (IN_W + 2 * FRAC_W) / 2;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_radicand;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_root;
  logic              out_exact;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid,
    output in_radicand,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_root,
    input  out_exact,
    input  out_tag
  );

  modport slave (
    input  in_valid,
    input  in_radicand,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_root,
    output out_exact,
    output out_tag
  );
endinterface

// File: rtl/sqrt_unit.sv
// ---------------------------------------------------------------------------
// sqrt_unit
//
// Handshaked fixed-point square-root engine for the heuristic path. The
// radicand is scaled by 2^(2*FRAC_W) and an OUT_W-bit root is produced one
// bit per cycle with a digit-by-digit recurrence. A caller tag rides along
// with each request so results can be matched to requests.
//
// Parameters:
//   IN_W    radicand width (even, >= 2)
//   FRAC_W  fraction bits in the result
//   TAG_W   passthrough tag width
//   Derived: RAD_W = IN_W + 2*FRAC_W, OUT_W = RAD_W/2
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   bus      sqrt_unit_if.slave (request and result channels)
//   state_o  current FSM state (0 IDLE, 1 CALC, 2 DONE) for debug/checkers
//
// Optional feature:
//   SQRT_ROUND_EN  when defined, out_root is rounded to nearest (saturating
//                  at all ones) instead of truncated. Rounding is purely
//                  combinational off the DONE registers.
//
// Timing: a request accepted at edge E raises out_valid after edge E+OUT_W.
// With out_ready held high a new request is accepted every OUT_W+2 cycles.
// ---------------------------------------------------------------------------
module sqrt_unit #(
  parameter int IN_W   = 20,
  parameter int FRAC_W = 4,
  parameter int TAG_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  sqrt_unit_if.slave   bus,
  output logic [1:0]   state_o
);

  localparam int RAD_W = IN_W + 2 * FRAC_W;
  localparam int OUT_W = RAD_W / 2;
  // Two extra bits: the partial remainder never exceeds 2*root, so after the
  // 2-bit left shift it still fits in OUT_W+2 bits.
  localparam int REM_W = OUT_W + 2;
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [RAD_W-1:0]   rad_q,   rad_d;
  logic [OUT_W-1:0]   root_q,  root_d;
  logic [REM_W-1:0]   rem_q,   rem_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [TAG_W-1:0]   tag_q,   tag_d;

  // One step of the recurrence, evaluated every cycle and used in CALC.
  logic [REM_W-1:0]   rem_shift;
  logic [REM_W-1:0]   trial;
  logic               take;
  logic [OUT_W:0]     root_shift;

  logic [OUT_W-1:0]   root_out;

  // -------------------------------------------------------------------------
  // Recurrence datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // Bring down the next two radicand bits into the partial remainder.
    rem_shift  = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    // Trial subtrahend is 4*root + 1; root has at most OUT_W-1 significant
    // bits before the last step, so this concatenation is lossless.
    trial      = {root_q, 2'b01};
    take       = (rem_shift >= trial);
    root_shift = {root_q, take};
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Scale by 2^(2*FRAC_W) so the integer root carries FRAC_W
          // fraction bits.
          rad_d   = RAD_W'(bus.in_radicand) << (2 * FRAC_W);
          tag_d   = bus.in_tag;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = CNT_W'(OUT_W - 1);
          state_d = CALC;
        end
      end

      CALC: begin
        rad_d  = rad_q << 2;
        root_d = root_shift[OUT_W-1:0];
        if (take) begin
          rem_d = rem_shift - trial;
        end else begin
          rem_d = rem_shift;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        // Registers are left untouched here, which keeps the result stable
        // for as long as the consumer stalls.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Result formatting
  // -------------------------------------------------------------------------
`ifdef SQRT_ROUND_EN
  // Round to nearest: x >= (q + 1/2)^2 reduces to r > q for integer r, q.
  // An all-ones root is left alone, which is the saturated value.
  always_comb begin
    root_out = root_q;
    if ((state_q == DONE) && (rem_q > {2'b00, root_q}) && (root_q != '1)) begin
      root_out = root_q + 1'b1;
    end
  end
`else
  assign root_out = root_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // in_ready is also forced low while rst is held, before the register has
  // had a chance to report IDLE.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_root  = root_out;
  assign bus.out_exact = (state_q == DONE) && (rem_q == '0);
  assign bus.out_tag   = tag_q;

  assign state_o = state_q;

endmodule

// File: tb/tb_sqrt_unit.sv
// ---------------------------------------------------------------------------
// tb_sqrt_unit
//
// Directed bench for sqrt_unit with default parameters (IN_W=20, FRAC_W=4,
// TAG_W=8, OUT_W=14). Expected roots are hand-computed constants; the
// rounded variants are selected with SQRT_ROUND_EN to match the build.
// ---------------------------------------------------------------------------
module tb_sqrt_unit;

  localparam int IN_W   = 20;
  localparam int FRAC_W = 4;
  localparam int TAG_W  = 8;
  localparam int OUT_W  = 14;
  localparam int LAT    = 14;
  localparam int BUDGET = 300;

`ifdef SQRT_ROUND_EN
  localparam logic [OUT_W-1:0] EXP_TWO   = 14'd23;
  localparam logic [OUT_W-1:0] EXP_THREE = 14'd28;
  localparam logic [OUT_W-1:0] EXP_TEN   = 14'd51;
`else
  localparam logic [OUT_W-1:0] EXP_TWO   = 14'd22;
  localparam logic [OUT_W-1:0] EXP_THREE = 14'd27;
  localparam logic [OUT_W-1:0] EXP_TEN   = 14'd50;
`endif

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         cyc;
  int         checks;
  int         errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sqrt_unit_if #(.IN_W(IN_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();

  sqrt_unit #(.IN_W(IN_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  // Scoreboard entries are {tag, root}.
  logic [TAG_W+OUT_W-1:0] exp_q[$];

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Presents a request and returns once it has been accepted (or the cycle
  // budget ran out). Called and returns at 1 time unit after a rising edge.
  task automatic send_req(input logic [IN_W-1:0] rad, input logic [TAG_W-1:0] tag,
                          output bit ok);
    int  n;
    bit  rdy;
    bus.in_valid    = 1'b1;
    bus.in_radicand = rad;
    bus.in_tag      = tag;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < BUDGET) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (rdy) ok = 1'b1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles until out_valid is seen after the accepting edge.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < BUDGET) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_root !== '0) begin errors++; $display("FAIL reset_out_root got %0d want 0", bus.out_root); end
    checks++; if (bus.out_exact !== 1'b0) begin errors++; $display("FAIL reset_out_exact got %0b want 0", bus.out_exact); end
    checks++; if (bus.out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %0h want 0", bus.out_tag); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b want 1", bus.in_ready); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL idle_state got %0d want 0", state_dbg); end
  endtask

  // One full request/result with latency and field checks.
  task automatic test_single(input string name, input logic [IN_W-1:0] rad,
                             input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] exp_root,
                             input logic exp_exact);
    bit ok;
    int lat;
    send_req(rad, tag, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_accept got timeout want accept", name); end
    wait_result(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT); end
    checks++; if (bus.out_root !== exp_root) begin errors++; $display("FAIL %s_root got %0d want %0d", name, bus.out_root, exp_root); end
    checks++; if (bus.out_exact !== exp_exact) begin errors++; $display("FAIL %s_exact got %0b want %0b", name, bus.out_exact, exp_exact); end
    checks++; if (bus.out_tag !== tag) begin errors++; $display("FAIL %s_tag got %0h want %0h", name, bus.out_tag, tag); end
    pop_result();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_release got valid=%0b ready=%0b want valid=0 ready=1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_zero();
    test_single("zero", 20'd0, 8'h5A, 14'd0, 1'b1);
  endtask

  task automatic test_exact();
    test_single("exact144", 20'd144, 8'h11, 14'd192, 1'b1);
    test_single("exact1", 20'd1, 8'h12, 14'd16, 1'b1);
  endtask

  task automatic test_inexact();
    test_single("inexact2", 20'd2, 8'h21, EXP_TWO, 1'b0);
    test_single("inexact3", 20'd3, 8'h22, EXP_THREE, 1'b0);
    test_single("inexact10", 20'd10, 8'h23, EXP_TEN, 1'b0);
  endtask

  task automatic test_max();
    test_single("max", 20'hFFFFF, 8'hFF, 14'h3FFF, 1'b0);
  endtask

  // Continuous producer with tags 1..4 against a consumer that stalls the
  // first result for 10 cycles, then drains with out_ready held high.
  task automatic test_back_to_back();
    bit                     p_ok;
    int                     n;
    int                     hs_cyc[4];
    logic [TAG_W+OUT_W-1:0] exp_e;
    bus.out_ready = 1'b0;
    fork
      begin : producer
        for (int t = 1; t <= 4; t++) begin
          send_req(20'(t * t), 8'(t), p_ok);
          if (p_ok) begin
            // Root of t*t at 4 fraction bits is 16*t.
            exp_q.push_back({8'(t), 14'(16 * t)});
            bus.in_valid = 1'b1;
          end else begin
            checks++; errors++;
            $display("FAIL b2b_accept got timeout want accept tag %0d", t);
          end
        end
        bus.in_valid = 1'b0;
      end
      begin : consumer
        for (int k = 0; k < 4; k++) begin
          n = 0;
          while (!bus.out_valid && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
          end
          checks++; if (!bus.out_valid) begin errors++; $display("FAIL b2b_valid got timeout want result %0d", k); end
          if (exp_q.size() > 0) exp_e = exp_q.pop_front();
          else exp_e = '0;
          checks++; if (bus.out_tag !== exp_e[TAG_W+OUT_W-1:OUT_W]) begin
            errors++; $display("FAIL b2b_tag got %0d want %0d", bus.out_tag, exp_e[TAG_W+OUT_W-1:OUT_W]);
          end
          checks++; if (bus.out_root !== exp_e[OUT_W-1:0]) begin
            errors++; $display("FAIL b2b_root got %0d want %0d", bus.out_root, exp_e[OUT_W-1:0]);
          end
          if (k == 0) begin
            for (int s = 0; s < 10; s++) begin
              @(posedge clk);
              #1;
              checks++;
              if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                  bus.out_root !== exp_e[OUT_W-1:0] || bus.out_tag !== exp_e[TAG_W+OUT_W-1:OUT_W] ||
                  bus.out_exact !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold got valid=%0b ready=%0b root=%0d tag=%0d exact=%0b want 1 0 %0d %0d 1",
                         bus.out_valid, bus.in_ready, bus.out_root, bus.out_tag, bus.out_exact,
                         exp_e[OUT_W-1:0], exp_e[TAG_W+OUT_W-1:OUT_W]);
              end
            end
            bus.out_ready = 1'b1;
          end
          @(posedge clk);
          #1;
          hs_cyc[k] = cyc;
          if (k > 0) begin
            checks++; if (hs_cyc[k] - hs_cyc[k-1] !== 16) begin
              errors++; $display("FAIL b2b_spacing got %0d want 16", hs_cyc[k] - hs_cyc[k-1]);
            end
          end
        end
        bus.out_ready = 1'b0;
      end
    join
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    send_req(20'hFFFFF, 8'h77, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_accept got timeout want accept"); end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL abort_calc_state got %0d want 1", state_dbg); end
    rst = 1'b1;
    #1;
    checks++; if (bus.out_root !== '0 || bus.out_tag !== '0 || bus.out_exact !== 1'b0 ||
                  bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL abort_clear got root=%0d tag=%0h exact=%0b valid=%0b ready=%0b state=%0d want all 0",
               bus.out_root, bus.out_tag, bus.out_exact, bus.out_valid, bus.in_ready, state_dbg);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result got valid want none"); end
    test_single("after_abort", 20'd144, 8'h33, 14'd192, 1'b1);
  endtask

  // ---------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------
  initial begin
    checks          = 0;
    errors          = 0;
    cyc             = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_radicand = '0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b0;

    test_reset();
    test_zero();
    test_exact();
    test_inexact();
    test_max();
    test_back_to_back();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
